id_char_gen: RTL and testbench

//   Stimulus-side counterpart of the identifier-recognising FSM: emits one ASCII

---
 rtl/id_char_gen.sv | 142 ++++++++++++++
 tb/tb_id_char_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/id_char_gen.sv
// id_char_gen: emits one identifier (letters, then digits, then a terminator)
// one character per valid/ready transfer.
module id_char_gen #(
    parameter int          CNT_W     = 4,
    parameter logic [7:0]  TERM_CHAR = 8'h5C
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] n_alpha_i,
    input  logic [CNT_W-1:0] n_digit_i,
    input  logic             char_ready_i,
    output logic [7:0]       char_o,
    output logic             char_valid_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {IDLE, ALPHA, DIGIT, TERM} state_t;

    localparam logic [7:0]       CH_A   = 8'h61;  // 'a'
    localparam logic [7:0]       CH_Z   = 8'h7A;  // 'z'
    localparam logic [7:0]       CH_0   = 8'h30;  // '0'
    localparam logic [7:0]       CH_9   = 8'h39;  // '9'
    localparam logic [CNT_W-1:0] CNT_1  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_0  = '0;

    state_t           state_q, state_d;
    logic [7:0]       char_q, char_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    // cnt_q is the 1-based index of the char currently on the bus within its field,
    // so it never exceeds the latched count and cannot overflow.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] na_q, na_d;
    logic [CNT_W-1:0] nd_q, nd_d;
    logic             xfer;

    assign xfer = valid_q & char_ready_i;

    // Next-state and output logic; registers hold unless a transfer or start occurs.
    always_comb begin
        state_d = state_q;
        char_d  = char_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        na_d    = na_q;
        nd_d    = nd_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    na_d    = n_alpha_i;
                    nd_d    = n_digit_i;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    cnt_d   = CNT_1;
                    if (n_alpha_i != CNT_0) begin
                        state_d = ALPHA;
                        char_d  = CH_A;
                    end else if (n_digit_i != CNT_0) begin
                        state_d = DIGIT;
                        char_d  = CH_0;
                    end else begin
                        state_d = TERM;
                        char_d  = TERM_CHAR;
                    end
                end
            end
            ALPHA: begin
                if (xfer) begin
                    if (cnt_q == na_q) begin
                        cnt_d = CNT_1;
                        if (nd_q != CNT_0) begin
                            state_d = DIGIT;
                            char_d  = CH_0;
                        end else begin
                            state_d = TERM;
                            char_d  = TERM_CHAR;
                        end
                    end else begin
                        cnt_d  = cnt_q + CNT_1;
                        char_d = (char_q == CH_Z) ? CH_A : char_q + 8'd1;
                    end
                end
            end
            DIGIT: begin
                if (xfer) begin
                    if (cnt_q == nd_q) begin
                        cnt_d   = CNT_1;
                        state_d = TERM;
                        char_d  = TERM_CHAR;
                    end else begin
                        cnt_d  = cnt_q + CNT_1;
                        char_d = (char_q == CH_9) ? CH_0 : char_q + 8'd1;
                    end
                end
            end
            TERM: begin
                if (xfer) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = CNT_0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= CNT_0;
            na_q    <= CNT_0;
            nd_q    <= CNT_0;
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            na_q    <= na_d;
            nd_q    <= nd_d;
        end
    end

    assign char_o       = char_q;
    assign char_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_id_char_gen.sv
// Directed bench for id_char_gen: expected chars are queued at start and
// popped by a monitor on every observed transfer.
module tb_id_char_gen;

    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             ready = 1'b1;
    logic [CNT_W-1:0] na_in = '0;
    logic [CNT_W-1:0] nd_in = '0;
    logic [7:0]       ch;
    logic             vld, busy, done;

    int               checks = 0;
    int               failures = 0;
    logic [7:0]       exp_q[$];
    logic             exp_done = 1'b0;
    logic             mon_en = 1'b0;
    logic [7:0]       mon_e;

    always #5 clk = ~clk;

    id_char_gen #(.CNT_W(CNT_W), .TERM_CHAR(8'h5C)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .n_alpha_i    (na_in),
        .n_digit_i    (nd_in),
        .char_ready_i (ready),
        .char_o       (ch),
        .char_valid_o (vld),
        .busy_o       (busy),
        .done_o       (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int na, input int nd);
        for (int i = 0; i < na; i++) exp_q.push_back(8'(8'h61 + (i % 26)));
        for (int i = 0; i < nd; i++) exp_q.push_back(8'(8'h30 + (i % 10)));
        exp_q.push_back(8'h5C);
    endtask

    // Scoreboard monitor: done must follow the terminator transfer by one cycle,
    // and every transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("done_pulse", {31'b0, done}, {31'b0, exp_done});
            exp_done = 1'b0;
            if (vld && ready) begin
                if (exp_q.size() == 0) begin
                    check("char_extra", {24'b0, ch}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("char", {24'b0, ch}, {24'b0, mon_e});
                    if (mon_e == 8'h5C) exp_done = 1'b1;
                end
            end
        end
    end

    // One identifier with ready held high; ign_k >= 0 pulses a conflicting start mid-stream.
    task automatic run_id(input int na, input int nd, input int ign_k, input string tag);
        int  k;
        bit  got;
        push_exp(na, nd);
        na_in = CNT_W'(na);
        nd_in = CNT_W'(nd);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_start"}, {31'b0, busy}, 32'd1);
        check({tag, "_vld_start"}, {31'b0, vld}, 32'd1);
        k = 0;
        got = 1'b0;
        while (k < 200 && !got) begin
            if (k == ign_k) begin
                start = 1'b1;
                na_in = CNT_W'(1);
                nd_in = CNT_W'(1);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check({tag, "_latency"}, k, na + nd + 1);
        check({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
        check({tag, "_vld_end"}, {31'b0, vld}, 32'd0);
        check({tag, "_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int k;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_char", {24'b0, ch}, 32'd0);
        check("rst_vld", {31'b0, vld}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // basic identifier
        run_id(4, 4, -1, "t1");
        @(posedge clk); #1;

        // backpressure on 'c'
        push_exp(4, 4);
        na_in = CNT_W'(4);
        nd_in = CNT_W'(4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (k < 20 && ch != 8'h63) begin
            @(posedge clk); #1;
            k++;
        end
        ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_char", {24'b0, ch}, 32'h63);
            check("stall_vld", {31'b0, vld}, 32'd1);
            @(posedge clk); #1;
        end
        ready = 1'b1;
        k = 0;
        while (k < 50 && !done) begin
            @(posedge clk); #1;
            k++;
        end
        check("stall_done", {31'b0, done}, 32'd1);
        check("stall_drained", exp_q.size(), 32'd0);
        @(posedge clk); #1;

        // empty identifier, then back-to-back digits-only from the done cycle
        run_id(0, 0, -1, "t3a");
        run_id(0, 12, -1, "t3b");
        @(posedge clk); #1;

        // letter fields, including wrap past 'z' and the maximum count
        run_id(15, 0, -1, "t4a");
        run_id(28, 0, -1, "t4b");
        run_id(31, 3, -1, "t4c");
        @(posedge clk); #1;

        // start while busy is ignored; start in done cycle chains immediately
        run_id(4, 4, 3, "t5a");
        run_id(2, 2, -1, "t5b");
        @(posedge clk); #1;

        // asynchronous reset during the digit field
        push_exp(2, 5);
        na_in = CNT_W'(2);
        nd_in = CNT_W'(5);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (k < 20 && ch != 8'h31) begin
            @(posedge clk); #1;
            k++;
        end
        check("t6_in_digit", {24'b0, ch}, 32'h31);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld", {31'b0, vld}, 32'd0);
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        check("t6_rst_char", {24'b0, ch}, 32'd0);
        check("t6_rst_done", {31'b0, done}, 32'd0);
        exp_q.delete();
        exp_done = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("t6_idle_vld", {31'b0, vld}, 32'd0);
        run_id(3, 2, -1, "t6b");
        repeat (2) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
